// File: rtl/md_if.sv
// Pipeline <-> multiply/divide unit signals: E/D instructions and operands in,
// stall/busy and HI/LO views out.
interface md_if;
    logic [31:0] instr_D;
    logic [31:0] instr_E;
    logic [31:0] rs_val_E;
    logic [31:0] rt_val_E;
    logic        stall_md;
    logic        busy;
    logic [31:0] hilo_out_E;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output instr_D, instr_E, rs_val_E, rt_val_E,
        input  stall_md, busy, hilo_out_E, hi, lo
    );

    modport slave (
        input  instr_D, instr_E, rs_val_E, rt_val_E,
        output stall_md, busy, hilo_out_E, hi, lo
    );
endinterface

// File: rtl/md_ctrl.sv
// HI/LO owner and multi-cycle mult/div sequencer for the 5-stage MIPS pipeline.
// Define MD_DIV_EN to build the divider and decode div/divu (otherwise they are nops).
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset_n,
    md_if.slave  md
);
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        commit;
    logic [31:0] hi_q, lo_q;
    logic [31:0] res_hi, res_lo, res_hi_nx, res_lo_nx;
    logic        res_ok, res_ok_nx;

    function automatic logic is_r(input logic [31:0] i, input logic [5:0] f);
        return (i[31:26] == 6'd0) && (i[5:0] == f);
    endfunction

    logic [31:0] rs, rt;
    logic mult_E, multu_E, div_E, divu_E, mthi_E, mtlo_E, mfhi_E, mflo_E;
    logic div_D, md_D, start_E;

    assign rs      = md.rs_val_E;
    assign rt      = md.rt_val_E;
    assign mult_E  = is_r(md.instr_E, F_MULT);
    assign multu_E = is_r(md.instr_E, F_MULTU);
    assign mthi_E  = is_r(md.instr_E, F_MTHI);
    assign mtlo_E  = is_r(md.instr_E, F_MTLO);
    assign mfhi_E  = is_r(md.instr_E, F_MFHI);
    assign mflo_E  = is_r(md.instr_E, F_MFLO);

`ifdef MD_DIV_EN
    assign div_E  = is_r(md.instr_E, F_DIV);
    assign divu_E = is_r(md.instr_E, F_DIVU);
    assign div_D  = is_r(md.instr_D, F_DIV) | is_r(md.instr_D, F_DIVU);
`else
    assign div_E  = 1'b0;
    assign divu_E = 1'b0;
    assign div_D  = 1'b0;
`endif

    assign md_D = is_r(md.instr_D, F_MULT) | is_r(md.instr_D, F_MULTU) | div_D |
                  is_r(md.instr_D, F_MFHI) | is_r(md.instr_D, F_MFLO) |
                  is_r(md.instr_D, F_MTHI) | is_r(md.instr_D, F_MTLO);
    assign start_E = mult_E | multu_E | div_E | divu_E;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

`ifdef MD_DIV_EN
    // Divisor forced to 1 when zero only to keep the divider defined; result is dropped.
    logic [31:0] rt_nz, q_u, r_u;
    logic signed [31:0] q_s, r_s;
    assign rt_nz = (rt == 32'd0) ? 32'd1 : rt;
    assign q_s   = $signed(rs) / $signed(rt_nz);
    assign r_s   = $signed(rs) % $signed(rt_nz);
    assign q_u   = rs / rt_nz;
    assign r_u   = rs % rt_nz;
`endif

    always_comb begin
        res_ok_nx = 1'b1;
        if (multu_E) {res_hi_nx, res_lo_nx} = prod_u;
        else         {res_hi_nx, res_lo_nx} = prod_s;
`ifdef MD_DIV_EN
        if (div_E) begin
            res_hi_nx = r_s;
            res_lo_nx = q_s;
            res_ok_nx = |rt;
        end else if (divu_E) begin
            res_hi_nx = r_u;
            res_lo_nx = q_u;
            res_ok_nx = |rt;
        end
`endif
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        case (state)
            IDLE: if (start_E) begin
                state_nx = RUN;
                cnt_nx   = (div_E | divu_E) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end
            RUN: if (cnt == 4'd1) begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
                commit   = 1'b1;
            end else begin
                cnt_nx = cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_ok <= 1'b0;
        end else begin
            if (state == IDLE && start_E) begin
                res_hi <= res_hi_nx;
                res_lo <= res_lo_nx;
                res_ok <= res_ok_nx;
            end
            if (commit) begin
                if (res_ok) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end else if (state == IDLE) begin
                if (mthi_E) hi_q <= rs;
                if (mtlo_E) lo_q <= rs;
            end
        end
    end

    assign md.busy       = (state == RUN);
    assign md.stall_md   = md_D & (start_E | (state == RUN));
    assign md.hilo_out_E = mfhi_E ? hi_q : (mflo_E ? lo_q : 32'd0);
    assign md.hi         = hi_q;
    assign md.lo         = lo_q;

    logic unused_bits;
    assign unused_bits = ^{md.instr_D[25:6], md.instr_E[25:6]};
endmodule
